pcie_mwr_tx: RTL and testbench

Upstream Memory Write (MWr) TLP initiator for the ECP3 PCIe x1 endpoint. It drives the 16-bit VC0 transmit interface of the PCIe core as the counterpart of the receive-side TLP decoder and slave bus. On a start pulse it checks posted credits and requests the link. It then emits a 3DW (optionally 4DW) MWr header, followed by 1–32 DW of payload fetched from a local 16-bit dual-port buffer. It is the write engine for host-directed DMA and sits beside `pcie_tlp` under `top`.

---
 rtl/pcie_tlp_pkg.sv | 25 ++
 rtl/pcie_mwr_hdr.sv | 43 ++++
 rtl/pcie_mwr_tx.sv | 198 +++++++++++++++++++
 tb/tb_pcie_mwr_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tlp_pkg.sv
// pcie_tlp_pkg
// Shared TLP constants for the PCIe x1 endpoint: fmt/type field encodings, the MWr
// initiator state encoding, the default maximum payload and a credit helper.
package pcie_tlp_pkg;

   localparam logic [1:0] FMT_3DW_D = 2'b10;
   localparam logic [1:0] FMT_4DW_D = 2'b11;
   localparam logic [4:0] TYPE_MEM  = 5'b00000;

   // Maximum MWr payload in DW (128-byte max payload size).
   localparam int MAX_DW_DEF = 32;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CRED = 3'd1;
   localparam logic [2:0] ST_REQ  = 3'd2;
   localparam logic [2:0] ST_HDR  = 3'd3;
   localparam logic [2:0] ST_DATA = 3'd4;
   localparam logic [2:0] ST_FIN  = 3'd5;

   // Posted data credits (4 DW each) needed for a payload of len DW: ceil(len / 4).
   function automatic logic [11:0] pd_need(input logic [5:0] len);
      return 12'(({1'b0, len} + 7'd3) >> 2);
   endfunction

endpackage

// File: rtl/pcie_mwr_hdr.sv
// pcie_mwr_hdr
// Combinational MWr header word mux. Selects the 16-bit header word for index idx,
// upper half of each DW first.
// Ports:
//   idx      in  3  : header word index (0..5 for 3DW, 0..7 for 4DW)
//   is_4dw   in  1  : 4DW header (64-bit address) when set
//   len      in  6  : payload length in DW
//   req_id   in  16 : {bus, dev, func}
//   addr_dw  in  30 : target address bits [31:2]
//   addr_hi  in  32 : upper address, used only for 4DW headers
//   word     out 16 : selected header word
module pcie_mwr_hdr
   import pcie_tlp_pkg::*;
(
   input  logic [2:0]  idx,
   input  logic        is_4dw,
   input  logic [5:0]  len,
   input  logic [15:0] req_id,
   input  logic [29:0] addr_dw,
   input  logic [31:0] addr_hi,
   output logic [15:0] word
);

   logic [31:0] dw0, dw1, dw2, dw3, dw_sel;
   logic [3:0]  last_be;

   always_comb begin
      last_be = (len == 6'd1) ? 4'h0 : 4'hF;
      // fmt/type, then TC/TD/EP/attr all zero, then the 10-bit length.
      dw0 = {1'b0, (is_4dw ? FMT_4DW_D : FMT_3DW_D), TYPE_MEM, 8'h00, 6'b0, 4'b0, len};
      dw1 = {req_id, 8'h00, last_be, 4'hF};
      dw2 = is_4dw ? addr_hi : {addr_dw, 2'b00};
      dw3 = {addr_dw, 2'b00};
      unique case (idx[2:1])
         2'd0:    dw_sel = dw0;
         2'd1:    dw_sel = dw1;
         2'd2:    dw_sel = dw2;
         default: dw_sel = dw3;
      endcase
      word = idx[0] ? dw_sel[15:0] : dw_sel[31:16];
   end

endmodule

// File: rtl/pcie_mwr_tx.sv
// pcie_mwr_tx
// Upstream Memory Write TLP initiator on the 16-bit VC0 TX interface. On start it
// checks posted credits, requests the link, sends a 3DW (or 4DW) MWr header and then
// 2*len payload words read from a local 16-bit buffer through a 2-entry skid.
// Optional feature: define PCIE_MWR_ADDR64_EN to send a 4DW header when addr_hi != 0.
// Ports:
//   pcie_clk, sys_rst            : clock, asynchronous active-high reset
//   bus_num/dev_num/func_num     : requester ID
//   start, addr_lo, addr_hi, len_dw : request (start sampled only when idle)
//   buf_rd_en/buf_rd_adr/buf_rd_dat : buffer read port, data one cycle after enable
//   tx_req/tx_rdy/tx_st/tx_end/tx_data : core TX handshake
//   tx_ca_ph/tx_ca_pd/tx_ca_p_recheck  : posted credits (MSB set = infinite)
//   busy, done, err, tlp_cnt     : status
module pcie_mwr_tx
   import pcie_tlp_pkg::*;
#(
   parameter int MAX_DW = MAX_DW_DEF
) (
   input  logic        pcie_clk,
   input  logic        sys_rst,
   input  logic [7:0]  bus_num,
   input  logic [4:0]  dev_num,
   input  logic [2:0]  func_num,
   input  logic        start,
   input  logic [31:0] addr_lo,
   input  logic [31:0] addr_hi,
   input  logic [5:0]  len_dw,
   output logic        buf_rd_en,
   output logic [5:0]  buf_rd_adr,
   input  logic [15:0] buf_rd_dat,
   output logic        tx_req,
   input  logic        tx_rdy,
   output logic        tx_st,
   output logic        tx_end,
   output logic [15:0] tx_data,
   input  logic [8:0]  tx_ca_ph,
   input  logic [12:0] tx_ca_pd,
   input  logic        tx_ca_p_recheck,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] tlp_cnt
);

   localparam logic [6:0] MAX_LEN = 7'(MAX_DW);

   logic [2:0]  state_q, state_d;
   logic [5:0]  len_q;
   logic [15:0] req_id_q;
   logic [29:0] addr_dw_q;
   logic [31:0] addr_hi_q;
   logic        is_4dw_q;
   logic [2:0]  hidx_q;
   logic [6:0]  wcnt_q, rd_cnt_q;
   logic        rd_pend_q;
   logic [1:0]  fcnt_q, fcnt_d;
   logic [15:0] skid0_q, skid0_d, skid1_q, skid1_d;
   logic        err_q;
   logic [15:0] cnt_q;

   logic [6:0]  total_w;
   logic [2:0]  hdr_last;
   logic [2:0]  skid_use;
   logic [15:0] hdr_word;
   logic        len_bad, accept, cred_ok, pop, pop_skid, push_skid, rd_en, last_word;

`ifdef PCIE_MWR_ADDR64_EN
   always_ff @(posedge pcie_clk or posedge sys_rst) begin
      if (sys_rst) begin
         addr_hi_q <= '0;
         is_4dw_q  <= 1'b0;
      end else if (accept) begin
         addr_hi_q <= addr_hi;
         is_4dw_q  <= (addr_hi != 32'h0);
      end
   end
   logic unused_addr;
   assign unused_addr = ^addr_lo[1:0];
`else
   assign addr_hi_q = '0;
   assign is_4dw_q  = 1'b0;
   logic unused_addr;
   assign unused_addr = ^{addr_hi, addr_lo[1:0]};
`endif

   assign total_w   = {len_q, 1'b0};
   assign hdr_last  = is_4dw_q ? 3'd7 : 3'd5;
   assign len_bad   = (len_dw == 6'd0) || ({1'b0, len_dw} > MAX_LEN);
   assign accept    = (state_q == ST_IDLE) && start && !len_bad;
   assign cred_ok   = (tx_ca_ph != 9'd0) &&
                      (tx_ca_pd[12] || (tx_ca_pd[11:0] >= pd_need(len_q))) &&
                      !tx_ca_p_recheck;
   assign last_word = (state_q == ST_DATA) && (wcnt_q == total_w - 7'd1);

   // A payload word leaves when the core takes it; it comes from the skid head or,
   // when the skid is empty, straight from the buffer read that just returned.
   assign pop       = (state_q == ST_DATA) && tx_rdy;
   assign pop_skid  = pop && (fcnt_q != 2'd0);
   assign push_skid = rd_pend_q && !(pop && (fcnt_q == 2'd0));

   // Words the skid will hold after this cycle; only read if one more still fits.
   assign skid_use  = {1'b0, fcnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};
   assign rd_en     = (((state_q == ST_HDR) && (hidx_q == hdr_last)) || (state_q == ST_DATA)) &&
                      (rd_cnt_q < total_w) && (skid_use < 3'd2);

   pcie_mwr_hdr u_hdr (
      .idx     (hidx_q),
      .is_4dw  (is_4dw_q),
      .len     (len_q),
      .req_id  (req_id_q),
      .addr_dw (addr_dw_q),
      .addr_hi (addr_hi_q),
      .word    (hdr_word)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_CRED;
         ST_CRED: if (cred_ok) state_d = ST_REQ;
         ST_REQ:  if (tx_rdy) state_d = ST_HDR;
         ST_HDR:  if (tx_rdy && (hidx_q == hdr_last)) state_d = ST_DATA;
         ST_DATA: if (tx_rdy && last_word) state_d = ST_FIN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fcnt_d  = fcnt_q;
      skid0_d = skid0_q;
      skid1_d = skid1_q;
      if (pop_skid) begin
         skid0_d = skid1_q;
         fcnt_d  = fcnt_q - 2'd1;
      end
      if (push_skid) begin
         if (fcnt_d == 2'd0) skid0_d = buf_rd_dat;
         else                skid1_d = buf_rd_dat;
         fcnt_d = fcnt_d + 2'd1;
      end
   end

   always_ff @(posedge pcie_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         req_id_q  <= '0;
         addr_dw_q <= '0;
         hidx_q    <= '0;
         wcnt_q    <= '0;
         rd_cnt_q  <= '0;
         rd_pend_q <= 1'b0;
         fcnt_q    <= '0;
         skid0_q   <= '0;
         skid1_q   <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         err_q     <= (state_q == ST_IDLE) && start && len_bad;
         rd_pend_q <= rd_en;
         fcnt_q    <= fcnt_d;
         skid0_q   <= skid0_d;
         skid1_q   <= skid1_d;
         if (accept) begin
            len_q     <= len_dw;
            req_id_q  <= {bus_num, dev_num, func_num};
            addr_dw_q <= addr_lo[31:2];
            hidx_q    <= '0;
            wcnt_q    <= '0;
            rd_cnt_q  <= '0;
         end else if (rd_en) begin
            rd_cnt_q <= rd_cnt_q + 7'd1;
         end
         if ((state_q == ST_HDR) && tx_rdy) hidx_q <= hidx_q + 3'd1;
         if (pop) wcnt_q <= wcnt_q + 7'd1;
         if (state_q == ST_FIN) cnt_q <= cnt_q + 16'd1;
      end
   end

   always_comb begin
      tx_data = '0;
      if (state_q == ST_HDR)       tx_data = hdr_word;
      else if (state_q == ST_DATA) tx_data = (fcnt_q != 2'd0) ? skid0_q : buf_rd_dat;
   end

   assign tx_req     = (state_q == ST_REQ);
   assign tx_st      = (state_q == ST_HDR) && (hidx_q == 3'd0);
   assign tx_end     = last_word;
   assign buf_rd_en  = rd_en;
   assign buf_rd_adr = rd_cnt_q[5:0];
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_FIN);
   assign err        = err_q;
   assign tlp_cnt    = cnt_q;

endmodule

// File: tb/tb_pcie_mwr_tx.sv
module tb_pcie_mwr_tx;

   logic        pcie_clk = 1'b0;
   logic        sys_rst  = 1'b0;
   logic [7:0]  bus_num  = '0;
   logic [4:0]  dev_num  = '0;
   logic [2:0]  func_num = '0;
   logic        start    = 1'b0;
   logic [31:0] addr_lo  = '0;
   logic [31:0] addr_hi  = '0;
   logic [5:0]  len_dw   = '0;
   logic        buf_rd_en;
   logic [5:0]  buf_rd_adr;
   logic [15:0] buf_rd_dat;
   logic        tx_req;
   logic        tx_rdy   = 1'b1;
   logic        tx_st, tx_end;
   logic [15:0] tx_data;
   logic [8:0]  tx_ca_ph = 9'd1;
   logic [12:0] tx_ca_pd = 13'd8;
   logic        tx_ca_p_recheck = 1'b0;
   logic        busy, done, err;
   logic [15:0] tlp_cnt;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_pkts = 0;

   logic [15:0] mem [64];

   always #4 pcie_clk = ~pcie_clk;

   // Buffer with one cycle read latency.
   always @(posedge pcie_clk) if (buf_rd_en) buf_rd_dat <= mem[buf_rd_adr];

   pcie_mwr_tx dut (
      .pcie_clk        (pcie_clk),
      .sys_rst         (sys_rst),
      .bus_num         (bus_num),
      .dev_num         (dev_num),
      .func_num        (func_num),
      .start           (start),
      .addr_lo         (addr_lo),
      .addr_hi         (addr_hi),
      .len_dw          (len_dw),
      .buf_rd_en       (buf_rd_en),
      .buf_rd_adr      (buf_rd_adr),
      .buf_rd_dat      (buf_rd_dat),
      .tx_req          (tx_req),
      .tx_rdy          (tx_rdy),
      .tx_st           (tx_st),
      .tx_end          (tx_end),
      .tx_data         (tx_data),
      .tx_ca_ph        (tx_ca_ph),
      .tx_ca_pd        (tx_ca_pd),
      .tx_ca_p_recheck (tx_ca_p_recheck),
      .busy            (busy),
      .done            (done),
      .err             (err),
      .tlp_cnt         (tlp_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [44:0] all_outs();
      return {buf_rd_en, buf_rd_adr, tx_req, tx_st, tx_end, tx_data, busy, done, err, tlp_cnt};
   endfunction

   // One MWr transaction. mode: 0 tx_rdy always high, 1 low every third cycle, 2 random.
   // *_w: cycles (from the cycle after start) during which that credit condition fails.
   // abort_at >= 0: assert reset in that loop cycle and return.
   task automatic run_pkt(input logic [15:0] rid, input logic [31:0] alo, input logic [31:0] ahi,
                          input logic [5:0] len, input int mode, input int ph_w, input int pd_w,
                          input int rc_w, input int abort_at);
      logic [15:0] exp_q[$];
      logic [15:0] got_q[$];
      logic        st_q[$];
      logic        end_q[$];
      logic [31:0] dw[4];
      logic [17:0] prev_out;
      logic        is4, in_pkt, stalled_prev;
      int          need, ndw, t_req, t_st, t_end, t_done, n_rd, rd_bad, hold_bad, req_bad;
      int          err_cnt, w;

      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      is4 = 1'b0;
`ifdef PCIE_MWR_ADDR64_EN
      is4 = (ahi != 32'h0);
`endif
      // Reference packet built straight from the field definitions.
      dw[0] = (is4 ? 32'h6000_0000 : 32'h4000_0000) + 32'(len);
      dw[1] = (32'(rid) << 16) + ((len == 6'd1) ? 32'h0F : 32'hFF);
      dw[2] = is4 ? ahi : (alo & 32'hFFFF_FFFC);
      dw[3] = alo & 32'hFFFF_FFFC;
      ndw = is4 ? 4 : 3;
      for (int i = 0; i < ndw; i++) begin
         exp_q.push_back(dw[i][31:16]);
         exp_q.push_back(dw[i][15:0]);
      end
      for (int i = 0; i < 2 * int'(len); i++) exp_q.push_back(mem[i]);
      need = (int'(len) + 3) / 4;

      @(posedge pcie_clk); #1;
      {bus_num, dev_num, func_num} = rid;
      addr_lo = alo;
      addr_hi = ahi;
      len_dw  = len;
      start   = 1'b1;
      tx_rdy  = 1'b1;
      t_req = -1; t_st = -1; t_end = -1; t_done = -1;
      n_rd = 0; rd_bad = 0; hold_bad = 0; req_bad = 0; err_cnt = 0;
      in_pkt = 1'b0; stalled_prev = 1'b0; prev_out = '0;

      for (int c = 0; c < 3000; c++) begin
         @(posedge pcie_clk); #1;
         // A second start while busy, with other request fields, must be ignored.
         start = (c == 5);
         if (c == 5) begin
            len_dw  = 6'($urandom_range(1, 32));
            addr_lo = $urandom;
         end
         case (mode)
            0:       tx_rdy = 1'b1;
            1:       tx_rdy = (c % 3 != 2);
            default: tx_rdy = ($urandom_range(0, 2) != 0);
         endcase
         tx_ca_ph = (c < ph_w) ? 9'd0 : ((ph_w == 0) ? 9'h100 : 9'd1);
         tx_ca_pd = (c < pd_w) ? 13'(need - 1) : ((pd_w == 0) ? 13'h1000 : 13'(need));
         tx_ca_p_recheck = (c < rc_w);
         if (c == abort_at) begin
            sys_rst = 1'b1;
            #1;
            check("abort_mid_packet", in_pkt, 1);
            check("reset_outputs_zero", all_outs(), 0);
            @(posedge pcie_clk); #1;
            sys_rst = 1'b0;
            start   = 1'b0;
            n_pkts  = 0;
            return;
         end
         @(negedge pcie_clk);
         if (buf_rd_en) begin
            if (buf_rd_adr != 6'(n_rd)) rd_bad++;
            n_rd++;
         end
         if (in_pkt && stalled_prev && ({tx_data, tx_st, tx_end} !== prev_out)) hold_bad++;
         if (!in_pkt && tx_st) begin
            in_pkt = 1'b1;
            t_st   = c;
         end
         if (tx_req && in_pkt) req_bad++;
         if (tx_req && t_req < 0) t_req = c;
         if (err) err_cnt++;
         stalled_prev = 1'b0;
         if (in_pkt) begin
            prev_out     = {tx_data, tx_st, tx_end};
            stalled_prev = !tx_rdy;
            if (tx_rdy) begin
               got_q.push_back(tx_data);
               st_q.push_back(tx_st);
               end_q.push_back(tx_end);
               if (tx_end) begin
                  in_pkt = 1'b0;
                  t_end  = c;
               end
            end
         end
         if (done) begin
            t_done = c;
            break;
         end
      end
      tx_ca_p_recheck = 1'b0;

      w = ph_w;
      if (pd_w > w) w = pd_w;
      if (rc_w > w) w = rc_w;
      check("done_seen", (t_done >= 0), 1);
      check("tx_req_latency", t_req, w + 1);
      check("word_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("word%0d", i), got_q[i], exp_q[i]);
         check($sformatf("st_end_flags%0d", i), {st_q[i], end_q[i]},
               {(i == 0), (i == exp_q.size() - 1)});
      end
      check("done_after_end", t_done, t_end + 1);
      if (mode == 0) begin
         check("st_after_req", t_st, t_req + 1);
         check("unstalled_length", t_end - t_st + 1, exp_q.size());
      end
      check("hold_during_stall", hold_bad, 0);
      check("tx_req_during_packet", req_bad, 0);
      check("read_order", rd_bad, 0);
      check("read_count", n_rd, 2 * int'(len));
      check("no_err", err_cnt, 0);
      n_pkts++;
      @(negedge pcie_clk);
      check("tlp_cnt", tlp_cnt, 16'(n_pkts));
      check("busy_after_done", busy, 0);
   endtask

   task automatic bad_len(input logic [5:0] len, input string tag);
      @(posedge pcie_clk); #1;
      len_dw = len;
      start  = 1'b1;
      @(posedge pcie_clk); #1;
      start = 1'b0;
      @(negedge pcie_clk);
      check({tag, "_err"}, {err, tx_req, busy}, 3'b100);
      @(negedge pcie_clk);
      check({tag, "_err_pulse"}, {err, tx_req, busy}, 3'b000);
   endtask

   initial begin
      #2 sys_rst = 1'b1;
      #1 check("reset_state", all_outs(), 0);
      repeat (3) @(posedge pcie_clk);
      #1 sys_rst = 1'b0;
      @(negedge pcie_clk);
      check("idle_after_reset", {busy, tx_req, tlp_cnt}, 0);

      // Directed 3DW, len 1.
      run_pkt(16'h0100, 32'h1000_0040, 32'h0, 6'd1, 0, 0, 0, 0, -1);
      // Max length with periodic stalls.
      run_pkt(16'($urandom), $urandom, 32'h0, 6'd32, 1, 0, 0, 0, -1);
      // No header credit for 50 cycles.
      run_pkt(16'($urandom), $urandom, 32'h0, 6'($urandom_range(1, 32)), 0, 50, 1, 0, -1);
      // Infinite data credit, len 32.
      run_pkt(16'($urandom), $urandom, 32'h0, 6'd32, 0, 0, 0, 0, -1);
      // Data credit one short, then exactly enough.
      run_pkt(16'($urandom), $urandom, 32'h0, 6'd32, 0, 1, 30, 0, -1);
      // Recheck strobe holds off the request.
      run_pkt(16'($urandom), $urandom, 32'h0, 6'd5, 2, 10, 1, 20, -1);
      // 64-bit address: 4DW only when the feature is built in.
      run_pkt(16'($urandom), $urandom, 32'h0000_0002, 6'd3, 0, 0, 0, 0, -1);

      bad_len(6'd0, "len0");
      bad_len(6'd33, "len33");

      // Reset during DATA, then a complete packet.
      run_pkt(16'($urandom), $urandom, 32'h0, 6'd16, 0, 0, 0, 0, 20);
      run_pkt(16'($urandom), $urandom, 32'h0, 6'($urandom_range(1, 32)), 2, 0, 0, 0, -1);

      for (int k = 0; k < 6; k++)
         run_pkt(16'($urandom), $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'h0,
                 6'($urandom_range(1, 32)), $urandom_range(0, 2), $urandom_range(0, 4),
                 $urandom_range(1, 4), $urandom_range(0, 4), -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
